demux16b1x4_reg: RTL and testbench

DEMUX16B1X4_REG -- requirements
Module: demux16b1x4_reg

---
 rtl/demux16b1x4_reg.sv | 99 +++++++++
 tb/tb_demux16b1x4_reg.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux16b1x4_reg.sv
// ---------------------------------------------------------------------------
// demux16b1x4_reg
//   Registered 1-to-4 demultiplexer. Each word accepted on the input port is
//   steered by in_addr into one of four single-entry channel registers. Each
//   channel then presents the word to its own consumer until it is taken.
//
// Handshake rules (apply to the input port and to each output channel):
//   A transfer happens on a rising clk edge where valid and ready are both 1.
//   The producer holds valid and its payload stable until that transfer.
//   Ready may depend combinationally on the addressed channel's state and on
//   that channel's out_ready, but never on in_valid.
//
// Ports
//   clk        : clock; all state changes on the rising edge
//   rst_n      : asynchronous active-low reset
//   in_valid   : upstream offers in_data for channel in_addr
//   in_ready   : the addressed channel can take a word this cycle
//   in_addr    : destination channel, 0..3
//   in_data    : word to deliver
//   Q0..Q3     : registered channel data
//   out_valid  : bit k set when Qk holds an undelivered word
//   out_ready  : bit k set when consumer k takes Qk this cycle
//   busy       : at least one channel holds an undelivered word
//   xfer_cnt   : number of accepted input words, wraps at 16 bits
// ---------------------------------------------------------------------------
module demux16b1x4_reg #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_addr,
  input  logic [WIDTH-1:0] in_data,
  output logic [WIDTH-1:0] Q0,
  output logic [WIDTH-1:0] Q1,
  output logic [WIDTH-1:0] Q2,
  output logic [WIDTH-1:0] Q3,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic             busy,
  output logic [15:0]      xfer_cnt
);

  // Per-channel state is just a valid bit and a data register.
  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [3:0]       valid_q;
  logic [3:0]       valid_d;
  logic [15:0]      cnt_q;
  logic [15:0]      cnt_d;
  logic             accept;

  always_comb begin
    // A full channel can still accept when it is being drained on the same
    // edge, which is what gives one word per cycle per channel.
    in_ready = !valid_q[in_addr] | out_ready[in_addr];
    accept   = in_valid & in_ready;

    // Drain first, then let a load of the same channel override it so a
    // simultaneous drain+load leaves the channel valid with the new word.
    valid_d = valid_q & ~out_ready;
    for (int k = 0; k < 4; k++) begin
      data_d[k] = data_q[k];
    end
    cnt_d = cnt_q;

    if (accept) begin
      valid_d[in_addr] = 1'b1;
      data_d[in_addr]  = in_data;
      cnt_d            = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
      end
      valid_q <= 4'b0000;
      cnt_q   <= 16'h0000;
    end else begin
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= data_d[k];
      end
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign Q0        = data_q[0];
  assign Q1        = data_q[1];
  assign Q2        = data_q[2];
  assign Q3        = data_q[3];
  assign out_valid = valid_q;
  assign busy      = |valid_q;
  assign xfer_cnt  = cnt_q;

endmodule

// File: tb/tb_demux16b1x4_reg.sv
module tb_demux16b1x4_reg;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [1:0]  in_addr;
  logic [15:0] in_data;
  logic [15:0] Q0, Q1, Q2, Q3;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic        busy;
  logic [15:0] xfer_cnt;

  always #5 clk = ~clk;

  demux16b1x4_reg #(.WIDTH(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_addr  (in_addr),
    .in_data  (in_data),
    .Q0       (Q0),
    .Q1       (Q1),
    .Q2       (Q2),
    .Q3       (Q3),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .xfer_cnt (xfer_cnt)
  );

  logic [15:0] dq [4];
  assign dq[0] = Q0;
  assign dq[1] = Q1;
  assign dq[2] = Q2;
  assign dq[3] = Q3;

  int total = 0;
  int bad   = 0;

  // ---------------- reference model ----------------
  // Four mailboxes, each holding at most one word, plus a running count.
  logic [15:0] m_q [4];
  logic        m_full [4];
  int          m_cnt;

  function automatic logic [3:0] m_valid_vec();
    logic [3:0] v;
    for (int k = 0; k < 4; k++) v[k] = m_full[k];
    return v;
  endfunction

  function automatic logic m_ready(input logic [1:0] a, input logic [3:0] ordy);
    return (!m_full[a]) || ordy[a];
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_q[k]    = 16'h0000;
      m_full[k] = 1'b0;
    end
    m_cnt = 0;
  endtask

  // Wait for one rising edge, apply the mailbox rules to the inputs that
  // were presented, then step 1 time unit past the edge.
  task automatic advance();
    logic acc;
    @(posedge clk);
    acc = in_valid && m_ready(in_addr, out_ready);
    for (int k = 0; k < 4; k++)
      if (m_full[k] && out_ready[k]) m_full[k] = 1'b0;
    if (acc) begin
      m_full[in_addr] = 1'b1;
      m_q[in_addr]    = in_data;
      m_cnt           = (m_cnt + 1) % 65536;
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] a, input logic [15:0] d,
                       input logic [3:0] ordy);
    in_valid  = v;
    in_addr   = a;
    in_data   = d;
    out_ready = ordy;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b1, 2'd1, 16'hBEEF, 4'b0000);
    model_reset();
    #1;
    total++;
    if (out_valid !== 4'b0000) begin bad++; $display("FAIL reset_valid got=%b exp=0000", out_valid); end
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++;
    if (xfer_cnt !== 16'h0000) begin bad++; $display("FAIL reset_cnt got=%h exp=0000", xfer_cnt); end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    // Edges while held in reset must not accept the offered word.
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      total++;
      if (dq[k] !== 16'h0000) begin bad++; $display("FAIL reset_q%0d got=%h exp=0000", k, dq[k]); end
    end
    total++;
    if (xfer_cnt !== 16'h0000) begin bad++; $display("FAIL reset_hold_cnt got=%h exp=0000", xfer_cnt); end
    @(negedge clk);
    drive(1'b0, 2'd0, 16'h0000, 4'b0000);
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_first_load();
    drive(1'b1, 2'd2, 16'hA5A5, 4'b0000);
    advance();
    drive(1'b0, 2'd0, 16'h0000, 4'b0000);
    total++;
    if (Q2 !== 16'hA5A5 || Q2 !== m_q[2]) begin bad++; $display("FAIL load_q2 got=%h exp=a5a5", Q2); end
    total++;
    if (out_valid !== 4'b0100) begin bad++; $display("FAIL load_valid got=%b exp=0100", out_valid); end
    total++;
    if (busy !== 1'b1) begin bad++; $display("FAIL load_busy got=%b exp=1", busy); end
    total++;
    if (xfer_cnt !== m_cnt[15:0]) begin bad++; $display("FAIL load_cnt got=%h exp=%h", xfer_cnt, m_cnt[15:0]); end
    total++;
    if (Q0 !== 16'h0 || Q1 !== 16'h0 || Q3 !== 16'h0) begin
      bad++; $display("FAIL load_others got=%h/%h/%h exp=0/0/0", Q0, Q1, Q3);
    end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 2'd2, 16'h1234, 4'b0000);
    #1;
    total++;
    if (in_ready !== m_ready(2'd2, 4'b0000) || in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_ready_low got=%b exp=0", in_ready);
    end
    advance();
    total++;
    if (Q2 !== m_q[2]) begin bad++; $display("FAIL bp_hold_q2 got=%h exp=%h", Q2, m_q[2]); end
    total++;
    if (out_valid !== m_valid_vec()) begin bad++; $display("FAIL bp_hold_valid got=%b exp=%b", out_valid, m_valid_vec()); end
    out_ready = 4'b0100;
    #1;
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_high got=%b exp=1", in_ready); end
    advance();
    drive(1'b0, 2'd0, 16'h0000, 4'b0000);
    total++;
    if (Q2 !== 16'h1234 || Q2 !== m_q[2]) begin bad++; $display("FAIL bp_q2_new got=%h exp=1234", Q2); end
    total++;
    if (out_valid[2] !== 1'b1) begin bad++; $display("FAIL bp_valid2 got=%b exp=1", out_valid[2]); end
    total++;
    if (xfer_cnt !== m_cnt[15:0]) begin bad++; $display("FAIL bp_cnt got=%h exp=%h", xfer_cnt, m_cnt[15:0]); end
    // Empty channel 2 for the following tests.
    out_ready = 4'b0100;
    advance();
    out_ready = 4'b0000;
  endtask

  task automatic test_stream();
    int start_cnt;
    start_cnt = m_cnt;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, 2'd1, 16'(i), 4'b0010);
      #1;
      total++;
      if (in_ready !== 1'b1) begin bad++; $display("FAIL stream_ready i=%0d got=%b exp=1", i, in_ready); end
      advance();
      total++;
      if (Q1 !== 16'(i) || out_valid[1] !== 1'b1) begin
        bad++; $display("FAIL stream_q1 i=%0d got=%h/%b exp=%h/1", i, Q1, out_valid[1], 16'(i));
      end
    end
    drive(1'b0, 2'd0, 16'h0000, 4'b0010);
    total++;
    if (xfer_cnt !== 16'((start_cnt + 8) % 65536)) begin
      bad++; $display("FAIL stream_cnt got=%h exp=%h", xfer_cnt, 16'((start_cnt + 8) % 65536));
    end
    advance();
    out_ready = 4'b0000;
  endtask

  task automatic test_drain_all();
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, 2'(k), 16'(k + 1), 4'b0000);
      advance();
    end
    total++;
    if (out_valid !== 4'b1111) begin bad++; $display("FAIL drain_loaded got=%b exp=1111", out_valid); end
    drive(1'b0, 2'd3, 16'hFFFF, 4'b1111);
    advance();
    out_ready = 4'b0000;
    total++;
    if (out_valid !== 4'b0000 || busy !== 1'b0) begin
      bad++; $display("FAIL drain_all got=%b busy=%b exp=0000 busy=0", out_valid, busy);
    end
    for (int k = 0; k < 4; k++) begin
      total++;
      if (dq[k] !== 16'(k + 1) || dq[k] !== m_q[k]) begin
        bad++; $display("FAIL drain_keep_q%0d got=%h exp=%h", k, dq[k], 16'(k + 1));
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
            16'($urandom), 4'($urandom_range(0, 15)));
      #1;
      total++;
      if (in_ready !== m_ready(in_addr, out_ready)) begin
        bad++; $display("FAIL rand_ready i=%0d got=%b exp=%b", i, in_ready, m_ready(in_addr, out_ready));
      end
      advance();
      total++;
      if (out_valid !== m_valid_vec() || busy !== (|m_valid_vec()) || xfer_cnt !== m_cnt[15:0]) begin
        bad++; $display("FAIL rand_state i=%0d got=%b/%b/%h exp=%b/%b/%h", i, out_valid, busy,
                        xfer_cnt, m_valid_vec(), |m_valid_vec(), m_cnt[15:0]);
      end
      for (int k = 0; k < 4; k++) begin
        total++;
        if (dq[k] !== m_q[k]) begin bad++; $display("FAIL rand_q%0d i=%0d got=%h exp=%h", k, i, dq[k], m_q[k]); end
      end
    end
    drive(1'b0, 2'd0, 16'h0000, 4'b0000);
  endtask

  task automatic test_async_reset();
    // Empty everything, then fill channels 1 and 3 only.
    drive(1'b0, 2'd0, 16'h0000, 4'b1111);
    advance();
    drive(1'b1, 2'd1, 16'h1111, 4'b0000);
    advance();
    drive(1'b1, 2'd3, 16'h3333, 4'b0000);
    advance();
    drive(1'b1, 2'd1, 16'h7777, 4'b0000);  // pending offer to a full channel
    total++;
    if (out_valid !== 4'b1010) begin bad++; $display("FAIL arst_pre got=%b exp=1010", out_valid); end
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    total++;
    if (out_valid !== 4'b0000 || busy !== 1'b0 || xfer_cnt !== 16'h0000) begin
      bad++; $display("FAIL arst_clear got=%b/%b/%h exp=0000/0/0000", out_valid, busy, xfer_cnt);
    end
    total++;
    if (Q0 !== 16'h0 || Q1 !== 16'h0 || Q2 !== 16'h0 || Q3 !== 16'h0) begin
      bad++; $display("FAIL arst_q got=%h/%h/%h/%h exp=0", Q0, Q1, Q2, Q3);
    end
    total++;
    if (in_ready !== 1'b1) begin bad++; $display("FAIL arst_ready got=%b exp=1", in_ready); end
    drive(1'b0, 2'd0, 16'h0000, 4'b0000);
    #1;
    rst_n = 1'b1;
    #1;
    drive(1'b1, 2'd2, 16'hA5A5, 4'b0000);
    advance();
    drive(1'b0, 2'd0, 16'h0000, 4'b0000);
    total++;
    if (Q2 !== 16'hA5A5 || out_valid !== 4'b0100 || xfer_cnt !== 16'h0001) begin
      bad++; $display("FAIL arst_reload got=%h/%b/%h exp=a5a5/0100/0001", Q2, out_valid, xfer_cnt);
    end
    total++;
    if (Q0 !== 16'h0 || Q1 !== 16'h0 || Q3 !== 16'h0) begin
      bad++; $display("FAIL arst_reload_others got=%h/%h/%h exp=0", Q0, Q1, Q3);
    end
  endtask

  task automatic test_wrap();
    int n;
    // Drain so channel 0 streams freely, then count up to 16'hFFFF.
    drive(1'b0, 2'd0, 16'h0000, 4'b1111);
    advance();
    n = 65535 - m_cnt;
    for (int i = 0; i < n; i++) begin
      drive(1'b1, 2'd0, 16'(i), 4'b0001);
      advance();
    end
    total++;
    if (xfer_cnt !== 16'hFFFF) begin bad++; $display("FAIL wrap_max got=%h exp=ffff", xfer_cnt); end
    drive(1'b1, 2'd0, 16'hCAFE, 4'b0001);
    advance();
    drive(1'b0, 2'd0, 16'h0000, 4'b0000);
    total++;
    if (xfer_cnt !== 16'h0000 || xfer_cnt !== m_cnt[15:0]) begin
      bad++; $display("FAIL wrap_zero got=%h exp=0000", xfer_cnt);
    end
    total++;
    if (Q0 !== 16'hCAFE) begin bad++; $display("FAIL wrap_q0 got=%h exp=cafe", Q0); end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    test_reset();
    test_first_load();
    test_backpressure();
    test_stream();
    test_drain_all();
    test_random();
    test_async_reset();
    test_wrap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
